// File: rtl/csoc_pkg.sv
// Shared encodings and defaults for the CSOC test-interface sequencer.
package csoc_pkg;

  localparam int unsigned NREGS_DEF = 1919;
  localparam int unsigned BIT_W     = 11;
  localparam int unsigned PCNT_W    = 16;
  localparam int unsigned BYTE_W    = 8;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_SCAN  = 2'd1,
    OP_RUN   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_RST_LO = 4'd1,
    S_RST_HI = 4'd2,
    S_LOAD   = 4'd3,
    S_SH_LO  = 4'd4,
    S_SH_HI  = 4'd5,
    S_PUSH   = 4'd6,
    S_RUN_LO = 4'd7,
    S_RUN_HI = 4'd8
  } state_e;

  // True for states that form the low phase of a CSOC clock period
  function automatic logic is_lo(input state_e s);
    return (s == S_RST_LO) || (s == S_SH_LO) || (s == S_RUN_LO);
  endfunction

  // True for states that form the high phase of a CSOC clock period
  function automatic logic is_hi(input state_e s);
    return (s == S_RST_HI) || (s == S_SH_HI) || (s == S_RUN_HI);
  endfunction

endpackage

// File: rtl/csoc_phase_gen.sv
// CSOC clock phase divider: strobes the last clk cycle of each low/high phase.
// Holding i_run low freezes the divider at the start of a low phase.
module csoc_phase_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_run,
  input  logic i_hi,
  output logic o_lo_last_c,
  output logic o_hi_last_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  assign w_last      = i_run && (r_cnt == DIV_W'(CLK_DIV - 1));
  assign o_lo_last_c = w_last && !i_hi;
  assign o_hi_last_c = w_last && i_hi;

  // Phase cycle counter; restarts at every phase boundary and while stalled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (!i_run || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/csoc_seq.sv
// Sequencer between the serial command parser and the CSOC test pins:
// CSOC reset, full scan-chain shift with byte streaming, and functional run.
module csoc_seq
  import csoc_pkg::*;
#(
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [15:0]       cmd_arg,
  output logic              done,
  output logic              err,
  output logic              busy,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              csoc_clk_o,
  output logic              csoc_rstn_o,
  output logic              csoc_test_se_o,
  output logic              csoc_test_tm_o,
  output logic [7:0]        csoc_data_o,
  input  logic [7:0]        csoc_data_i
);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NREGS - 1);

  state_e              r_state;
  state_e              w_next;

  logic [PCNT_W-1:0]   r_pcnt;
  logic [BIT_W-1:0]    r_bitcnt;
  logic                r_final;
  logic [BYTE_W-1:0]   r_sin;
  logic [BYTE_W-1:0]   r_sout;
  logic                r_sdi;

  logic                r_done;
  logic                r_err;
  logic                r_busy;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_clk;
  logic                r_rstn;
  logic                r_se;
  logic                r_tm;

  logic                w_done_d;
  logic                w_err_d;
  logic                w_busy_d;
  logic                w_in_ready_d;
  logic                w_out_valid_d;
  logic                w_clk_d;
  logic                w_rstn_d;
  logic                w_se_d;
  logic                w_tm_d;

  op_e                 w_op;
  logic                w_accept;
  logic                w_run;
  logic                w_hi;
  logic                w_lo_last;
  logic                w_hi_last;
  logic                w_byte_end;
  logic                w_last_pulse;
  logic                w_load_hs;
  logic                w_push_hs;
  logic                w_unused_ok;

  assign w_op         = op_e'(cmd_op);
  assign w_accept     = cmd_valid && (r_state == S_IDLE);
  assign w_run        = is_lo(r_state) || is_hi(r_state);
  assign w_hi         = is_hi(r_state);
  assign w_byte_end   = (r_bitcnt == LAST_BIT) || (r_bitcnt[2:0] == 3'd7);
  assign w_last_pulse = (r_pcnt == PCNT_W'(1));
  assign w_load_hs    = (r_state == S_LOAD) && in_valid && r_in_ready;
  assign w_push_hs    = (r_state == S_PUSH) && out_ready && r_out_valid;
  assign w_unused_ok  = ^csoc_data_i[6:0];

  csoc_phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk         (clk),
    .rstn        (rstn),
    .i_run       (w_run),
    .i_hi        (w_hi),
    .o_lo_last_c (w_lo_last),
    .o_hi_last_c (w_hi_last)
  );

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (w_op)
            OP_RESET: w_next = S_RST_LO;
            OP_SCAN:  w_next = S_LOAD;
            OP_RUN:   w_next = (cmd_arg == 16'd0) ? S_IDLE : S_RUN_LO;
            default:  w_next = S_IDLE;
          endcase
        end
      end
      S_RST_LO: if (w_lo_last) w_next = S_RST_HI;
      S_RST_HI: if (w_hi_last) w_next = w_last_pulse ? S_IDLE : S_RST_LO;
      S_RUN_LO: if (w_lo_last) w_next = S_RUN_HI;
      S_RUN_HI: if (w_hi_last) w_next = w_last_pulse ? S_IDLE : S_RUN_LO;
      S_LOAD:   if (w_load_hs) w_next = S_SH_LO;
      S_SH_LO:  if (w_lo_last) w_next = S_SH_HI;
      S_SH_HI:  if (w_hi_last) w_next = w_byte_end ? S_PUSH : S_SH_LO;
      S_PUSH:   if (w_push_hs) w_next = r_final ? S_IDLE : S_LOAD;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so pins line up with the state
  always_comb begin
    w_done_d      = 1'b0;
    w_err_d       = 1'b0;
    w_busy_d      = 1'b0;
    w_in_ready_d  = 1'b0;
    w_out_valid_d = 1'b0;
    w_clk_d       = 1'b0;
    w_rstn_d      = 1'b1;
    w_se_d        = 1'b0;
    w_tm_d        = 1'b0;

    w_done_d      = (w_next == S_IDLE) && ((r_state != S_IDLE) || cmd_valid);
    w_err_d       = (r_state == S_IDLE) && cmd_valid && (w_op == OP_RSVD);
    w_busy_d      = (w_next != S_IDLE);
    w_in_ready_d  = (w_next == S_LOAD);
    w_out_valid_d = (w_next == S_PUSH);
    w_clk_d       = is_hi(w_next);
    w_rstn_d      = !((w_next == S_RST_LO) || (w_next == S_RST_HI));
    w_se_d        = (w_next == S_LOAD) || (w_next == S_SH_LO) ||
                    (w_next == S_SH_HI) || (w_next == S_PUSH);
    w_tm_d        = w_se_d || (w_next == S_RUN_LO) || (w_next == S_RUN_HI);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_clk       <= 1'b0;
      r_rstn      <= 1'b0;
      r_se        <= 1'b0;
      r_tm        <= 1'b0;
    end else begin
      r_done      <= w_done_d;
      r_err       <= w_err_d;
      r_busy      <= w_busy_d;
      r_in_ready  <= w_in_ready_d;
      r_out_valid <= w_out_valid_d;
      r_clk       <= w_clk_d;
      r_rstn      <= w_rstn_d;
      r_se        <= w_se_d;
      r_tm        <= w_tm_d;
    end
  end

  // Pulse and bit counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pcnt   <= '0;
      r_bitcnt <= '0;
      r_final  <= 1'b0;
    end else if (w_accept) begin
      r_pcnt   <= ((w_op == OP_RESET) && (cmd_arg == 16'd0)) ? PCNT_W'(1) : cmd_arg;
      r_bitcnt <= '0;
      r_final  <= 1'b0;
    end else begin
      if (w_hi_last && ((r_state == S_RST_HI) || (r_state == S_RUN_HI))) begin
        r_pcnt <= r_pcnt - PCNT_W'(1);
      end
      if (w_hi_last && (r_state == S_SH_HI)) begin
        if (r_bitcnt != LAST_BIT) begin
          r_bitcnt <= r_bitcnt + BIT_W'(1);
        end
        if (w_byte_end) begin
          r_final <= (r_bitcnt == LAST_BIT);
        end
      end
    end
  end

  // Scan data path: input byte shifter, scan-in pin, output byte capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sin  <= '0;
      r_sdi  <= 1'b0;
      r_sout <= '0;
    end else begin
      if (w_load_hs) begin
        r_sin <= in_data;
      end else if (w_hi_last && (r_state == S_SH_HI)) begin
        r_sin <= {1'b0, r_sin[BYTE_W-1:1]};
      end

      if (w_load_hs) begin
        r_sdi <= in_data[0];
      end else if (w_hi_last && (r_state == S_SH_HI) && !w_byte_end) begin
        r_sdi <= r_sin[1];
      end else if (w_next == S_IDLE) begin
        r_sdi <= 1'b0;
      end

      if (w_load_hs) begin
        r_sout <= '0;
      end else if (w_lo_last && (r_state == S_SH_LO)) begin
        r_sout[r_bitcnt[2:0]] <= csoc_data_i[7];
      end
    end
  end

  assign cmd_ready      = (r_state == S_IDLE);
  assign done           = r_done;
  assign err            = r_err;
  assign busy           = r_busy;
  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign out_data       = r_sout;
  assign csoc_clk_o     = r_clk;
  assign csoc_rstn_o    = r_rstn;
  assign csoc_test_se_o = r_se;
  assign csoc_test_tm_o = r_tm;
  assign csoc_data_o    = {7'd0, r_sdi};

endmodule

// File: tb/tb_csoc_seq.sv
// Directed bench for csoc_seq with a behavioural CSOC scan-chain model.
module tb_csoc_seq;
  import csoc_pkg::*;

  localparam int unsigned NREGS   = 1919;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned NBYTES  = (NREGS + 7) / 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        done;
  logic        err;
  logic        busy;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        csoc_clk_o;
  logic        csoc_rstn_o;
  logic        csoc_test_se_o;
  logic        csoc_test_tm_o;
  logic [7:0]  csoc_data_o;
  logic [7:0]  csoc_data_i;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csoc_seq #(
    .NREGS   (NREGS),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_arg        (cmd_arg),
    .done           (done),
    .err            (err),
    .busy           (busy),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .csoc_clk_o     (csoc_clk_o),
    .csoc_rstn_o    (csoc_rstn_o),
    .csoc_test_se_o (csoc_test_se_o),
    .csoc_test_tm_o (csoc_test_tm_o),
    .csoc_data_o    (csoc_data_o),
    .csoc_data_i    (csoc_data_i)
  );

  // CSOC scan chain model: shifts toward bit 0 on each scan clock rise
  logic [NREGS-1:0] chain;
  logic [NREGS-1:0] pre_val;
  logic             pre_stb = 1'b0;
  always @(posedge csoc_clk_o or posedge pre_stb) begin
    if (pre_stb) chain <= pre_val;
    else if (csoc_test_se_o) chain <= {csoc_data_o[0], chain[NREGS-1:1]};
  end
  assign csoc_data_i = {chain[0], 7'd0};

  // CSOC clock pulse counters
  int n_pulse = 0;
  int n_pulse_rst = 0;
  always @(posedge csoc_clk_o) begin
    n_pulse = n_pulse + 1;
    if (!csoc_rstn_o) n_pulse_rst = n_pulse_rst + 1;
  end

  // Output byte capture and stall-behaviour monitor
  logic [7:0] got [1024];
  int   n_out = 0;
  int   v_clk = 0;
  int   v_se = 0;
  int   v_hold = 0;
  int   n_stall = 0;
  logic hold_prev = 1'b0;
  logic [7:0] od_prev = 8'd0;
  always @(posedge clk) begin
    if (rstn) begin
      if (out_valid && out_ready) begin
        got[n_out % 1024] = out_data;
        n_out = n_out + 1;
      end
      if ((in_ready && !in_valid) || (out_valid && !out_ready)) n_stall = n_stall + 1;
      if ((in_ready || out_valid) && csoc_clk_o) v_clk = v_clk + 1;
      if ((in_ready || out_valid) && !csoc_test_se_o) v_se = v_se + 1;
      if (hold_prev && (out_data !== od_prev)) v_hold = v_hold + 1;
      hold_prev = out_valid && !out_ready;
      od_prev   = out_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Handshake driver: optional random gaps on in_valid / out_ready
  logic base_iv = 1'b0;
  logic base_or = 1'b0;
  logic stall_mode = 1'b0;
  always @(negedge clk) begin
    in_valid  = base_iv && (!stall_mode || ($urandom_range(0, 3) == 0));
    out_ready = base_or && (!stall_mode || ($urandom_range(0, 3) == 0));
  end

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_assert = n_assert + 1;
    if (got_v !== exp_v) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
    @(negedge clk);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    while (!done && (cyc < max_cyc)) begin
      @(negedge clk);
      cyc = cyc + 1;
    end
  endtask

  function automatic logic [NREGS-1:0] gen_pat(input logic [31:0] seed);
    logic [NREGS-1:0] r;
    logic [31:0] s;
    s = seed;
    for (int j = 0; j < NREGS; j++) begin
      s = s ^ (s << 13);
      s = s ^ (s >> 17);
      s = s ^ (s << 5);
      r[j] = s[0];
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [NREGS-1:0] p, input int b);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 * b + i) < NREGS) r[i] = p[8 * b + i];
    end
    return r;
  endfunction

  function automatic logic [25:0] pins();
    return {cmd_ready, done, err, busy, in_ready, out_valid, out_data,
            csoc_clk_o, csoc_rstn_o, csoc_test_se_o, csoc_test_tm_o, csoc_data_o};
  endfunction

  task automatic scan_check(input string tag, input logic stall, input logic [NREGS-1:0] pre);
    int base;
    int cyc;
    int mism;
    logic [7:0] a5;
    a5 = 8'hA5;
    pre_val = pre;
    pre_stb = 1'b1;
    #1 pre_stb = 1'b0;
    base       = n_out;
    base_iv    = 1'b1;
    base_or    = 1'b1;
    stall_mode = stall;
    send_cmd(OP_SCAN, 16'd0);
    chk({tag, "_inrdy"}, in_ready, 1);
    chk({tag, "_se_tm"}, {csoc_test_se_o, csoc_test_tm_o}, 2'b11);
    wait_done(30000, cyc);
    stall_mode = 1'b0;
    chk({tag, "_done"}, {done, err}, 2'b10);
    if (!stall) chk({tag, "_cycles"}, cyc, 2 * CLK_DIV * NREGS + 2 * NBYTES);
    chk({tag, "_nbytes"}, n_out - base, NBYTES);
    chk({tag, "_byte0"}, got[base % 1024], exp_byte(pre, 0));
    chk({tag, "_bytelast"}, got[(base + NBYTES - 1) % 1024], exp_byte(pre, NBYTES - 1));
    mism = 0;
    for (int b = 0; b < NBYTES; b++) begin
      if (got[(base + b) % 1024] !== exp_byte(pre, b)) mism = mism + 1;
    end
    chk({tag, "_bytes_bad"}, mism, 0);
    mism = 0;
    for (int j = 0; j < NREGS; j++) begin
      if (chain[j] !== a5[j % 8]) mism = mism + 1;
    end
    chk({tag, "_chain_bad"}, mism, 0);
    base_iv = 1'b0;
    base_or = 1'b0;
  endtask

  initial begin
    int cyc;
    int p0;
    int pr0;
    logic [7:0] snap;
    logic [NREGS-1:0] pat1;
    logic [NREGS-1:0] pat2;

    rstn      = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_arg   = 16'd0;
    in_data   = 8'hA5;
    pat1      = gen_pat(32'h1234_5678);
    pat2      = gen_pat(32'h0BAD_F00D);

    repeat (3) @(negedge clk);
    chk("reset_values", pins(), 26'h200_0000);
    rstn = 1'b1;
    @(negedge clk);
    chk("rstn_release", {csoc_rstn_o, cmd_ready, busy}, 3'b110);

    // RUN for 3 pulses
    p0 = n_pulse;
    send_cmd(OP_RUN, 16'd3);
    chk("run3_pins", {busy, csoc_test_tm_o, csoc_test_se_o, csoc_rstn_o}, 4'b1101);
    wait_done(100, cyc);
    chk("run3_latency", cyc, 12);
    chk("run3_done_err", {done, err, cmd_ready}, 3'b101);
    chk("run3_pulses", n_pulse - p0, 3);
    @(negedge clk);
    chk("run3_done_pulse", {done, busy, csoc_test_tm_o}, 3'b000);

    // RUN with zero pulses
    p0 = n_pulse;
    send_cmd(OP_RUN, 16'd0);
    chk("run0_done", {done, err, busy}, 3'b100);
    chk("run0_pulses", n_pulse - p0, 0);

    // RESET with arg 0 gives one pulse
    p0 = n_pulse; pr0 = n_pulse_rst;
    send_cmd(OP_RESET, 16'd0);
    chk("rst0_low", {csoc_rstn_o, csoc_test_tm_o, csoc_test_se_o}, 3'b000);
    wait_done(100, cyc);
    chk("rst0_latency", cyc, 4);
    chk("rst0_pulses", {16'(n_pulse - p0), 16'(n_pulse_rst - pr0)}, {16'd1, 16'd1});
    chk("rst0_release", {csoc_rstn_o, done}, 2'b11);

    // RESET with 5 pulses
    p0 = n_pulse; pr0 = n_pulse_rst;
    send_cmd(OP_RESET, 16'd5);
    wait_done(200, cyc);
    chk("rst5_latency", cyc, 20);
    chk("rst5_pulses", {16'(n_pulse - p0), 16'(n_pulse_rst - pr0)}, {16'd5, 16'd5});
    chk("rst5_release", csoc_rstn_o, 1);

    // Reserved op: immediate done+err, pins untouched
    snap = {csoc_clk_o, csoc_rstn_o, csoc_test_se_o, csoc_test_tm_o, csoc_data_o[3:0]};
    p0 = n_pulse;
    send_cmd(OP_RSVD, 16'd7);
    chk("rsvd_done_err", {done, err, busy}, 3'b110);
    @(negedge clk);
    chk("rsvd_pulse_end", {done, err}, 2'b00);
    repeat (3) @(negedge clk);
    chk("rsvd_pins", {csoc_clk_o, csoc_rstn_o, csoc_test_se_o, csoc_test_tm_o, csoc_data_o[3:0]}, snap);
    chk("rsvd_pulses", n_pulse - p0, 0);

    // Full scan, no stalls, then again with random stalls
    scan_check("scan_clean", 1'b0, pat1);
    scan_check("scan_stall", 1'b1, pat1);
    chk("stall_seen", n_stall > 50, 1);

    // Abort a scan around bit 500 with async reset
    base_iv = 1'b1;
    base_or = 1'b1;
    p0 = n_pulse;
    send_cmd(OP_SCAN, 16'd0);
    cyc = 0;
    while (((n_pulse - p0) < 500) && (cyc < 5000)) begin
      @(negedge clk);
      cyc = cyc + 1;
    end
    chk("abort_reached", (n_pulse - p0) >= 500, 1);
    #2 rstn = 1'b0;
    #1 chk("abort_async", pins(), 26'h200_0000);
    base_iv = 1'b0;
    base_or = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle", {done, busy, cmd_ready, csoc_rstn_o}, 4'b0011);

    scan_check("scan_after_abort", 1'b0, pat2);

    chk("mon_clk_in_stall", v_clk, 0);
    chk("mon_se_in_stall", v_se, 0);
    chk("mon_out_hold", v_hold, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
